// File: rtl/rob_commit_source_pkg.sv
// Shared ROB types: entry/writeback/tag structs, exception and branch enums, sizing constants.
package rob_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_SLOTS = 2;
   localparam int ROB_ROW_W = $clog2(ROB_DEPTH);

   typedef enum logic [4:0] {
      EXC_INSTR_MISALIGN = 5'd0,
      EXC_INSTR_ACCESS   = 5'd1,
      EXC_ILLEGAL_INSTR  = 5'd2,
      EXC_BREAKPOINT     = 5'd3,
      EXC_LOAD_MISALIGN  = 5'd4,
      EXC_LOAD_ACCESS    = 5'd5,
      EXC_STORE_MISALIGN = 5'd6,
      EXC_STORE_ACCESS   = 5'd7,
      EXC_ECALL_U        = 5'd8,
      EXC_ECALL_S        = 5'd9,
      EXC_ECALL_M        = 5'd11,
      EXC_INSTR_PAGE     = 5'd12,
      EXC_LOAD_PAGE      = 5'd13,
      EXC_STORE_PAGE     = 5'd15
   } ExceptionType;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_COND = 3'd1,
      BR_JAL  = 3'd2,
      BR_JALR = 3'd3,
      BR_CALL = 3'd4,
      BR_RET  = 3'd5
   } BranchType;

   typedef struct packed {
      logic         valid;
      logic         busy;
      logic         committed;
      logic [31:0]  pc;
      logic [4:0]   dstLAddr;
      logic [5:0]   dstPAddr;
      logic [5:0]   dstPStale;
      logic         dstwe;
      BranchType    branchType;
      logic         branchTaken;
      logic         predTaken;
      logic [31:0]  branchAddr;
      logic [31:0]  predAddr;
      logic         causeExc;
      logic         exception;
      ExceptionType excCode;
      logic [1:0]   nlpBimState;
   } rob_entry_t;

   typedef struct packed {
      logic         branchTaken;
      logic [31:0]  branchAddr;
      logic         causeExc;
      logic         exception;
      ExceptionType excCode;
   } rob_wb_t;

   typedef struct packed {
      logic [ROB_ROW_W-1:0] row;
      logic                 slot;
   } rob_tag_t;

   // Folds execute results into a stored entry; payload fields from dispatch are kept.
   function automatic rob_entry_t rob_wb_merge(rob_entry_t e, rob_wb_t w);
      rob_entry_t m;
      m             = e;
      m.branchTaken = w.branchTaken;
      m.branchAddr  = w.branchAddr;
      m.causeExc    = w.causeExc;
      m.exception   = w.exception;
      m.excCode     = w.excCode;
      return m;
   endfunction

endpackage

// File: rtl/rob_commit_source_if.sv
// Dispatch, writeback and commit bus of the reorder buffer; slave is the ROB, master the pipeline.
interface rob_commit_source_if
   import rob_pkg::*;
#(
   parameter int DEPTH    = ROB_DEPTH,
   parameter int WB_PORTS = 4,
   parameter int ROW_W    = $clog2(DEPTH)
) ();

   logic                flush;
   logic                dispatch_valid;
   logic                dispatch_ready;
   rob_entry_t          dispatch_uop0;
   rob_entry_t          dispatch_uop1;
   logic [ROW_W-1:0]    dispatch_row;
   logic [WB_PORTS-1:0] wb_valid;
   rob_tag_t            wb_tag  [WB_PORTS];
   rob_wb_t             wb_info [WB_PORTS];
   logic                commit_valid;
   logic                commit_ready;
   rob_entry_t          commit_uop0;
   rob_entry_t          commit_uop1;
   logic                rob_empty;

   modport slave (
      input  flush, dispatch_valid, dispatch_uop0, dispatch_uop1,
      input  wb_valid, wb_tag, wb_info, commit_ready,
      output dispatch_ready, dispatch_row, commit_valid,
      output commit_uop0, commit_uop1, rob_empty
   );

   modport master (
      output flush, dispatch_valid, dispatch_uop0, dispatch_uop1,
      output wb_valid, wb_tag, wb_info, commit_ready,
      input  dispatch_ready, dispatch_row, commit_valid,
      input  commit_uop0, commit_uop1, rob_empty
   );

endinterface

// File: rtl/rob_commit_source_ptr_ctrl.sv
// Head/tail/count bookkeeping for the ROB ring; flush outranks push and pop.
module rob_ptr_ctrl #(
   parameter int DEPTH = 16,
   parameter int ROW_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   output logic [ROW_W-1:0] o_head,
   output logic [ROW_W-1:0] o_tail,
   output logic [ROW_W:0]   o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [ROW_W-1:0] r_head;
   logic [ROW_W-1:0] r_tail;
   logic [ROW_W:0]   r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Pointers wrap through their width; only the count separates full from empty.
   assign o_head  = r_head;
   assign o_tail  = r_tail;
   assign o_count = r_count;
   assign o_full  = (r_count == (ROW_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/rob_commit_source.sv
// Reorder buffer of two-slot rows: allocates at dispatch, tracks writeback, offers the oldest row to commit.
module rob_commit_source
   import rob_pkg::*;
#(
   parameter int DEPTH    = ROB_DEPTH,
   parameter int WB_PORTS = 4,
   parameter int ROW_W    = $clog2(DEPTH)
) (
   input logic                 clk,
   input logic                 rst,
   rob_commit_source_if.slave  bus
);

   logic       r_valid [DEPTH][ROB_SLOTS];
   logic       r_busy  [DEPTH][ROB_SLOTS];
   rob_entry_t r_data  [DEPTH][ROB_SLOTS];

   logic [ROW_W-1:0]    w_head;
   logic [ROW_W-1:0]    w_tail;
   logic [ROW_W:0]      w_count;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_head_done;
   logic                w_commit_valid;
   logic [ROW_W-1:0]    w_wb_row [WB_PORTS];
   logic [WB_PORTS-1:0] w_wb_hit;

   rob_ptr_ctrl #(.DEPTH(DEPTH), .ROW_W(ROW_W)) u_ptr (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_tail  (w_tail),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_push = bus.dispatch_valid && !w_full;
   assign w_pop  = w_commit_valid && bus.commit_ready;

   // A writeback lands only on a live row (offset from head below count) and a still-busy valid slot.
   for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
      logic [ROW_W-1:0] w_off;
      assign w_wb_row[p] = ROW_W'(bus.wb_tag[p].row);
      assign w_off       = w_wb_row[p] - w_head;
      assign w_wb_hit[p] = bus.wb_valid[p] && ({1'b0, w_off} < w_count)
                           && r_valid[w_wb_row[p]][bus.wb_tag[p].slot]
                           && r_busy[w_wb_row[p]][bus.wb_tag[p].slot];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            for (int s = 0; s < ROB_SLOTS; s++) begin
               r_valid[r][s] <= 1'b0;
               r_busy[r][s]  <= 1'b0;
            end
         end
      end else if (bus.flush) begin
         for (int r = 0; r < DEPTH; r++) begin
            for (int s = 0; s < ROB_SLOTS; s++) begin
               r_valid[r][s] <= 1'b0;
               r_busy[r][s]  <= 1'b0;
            end
         end
      end else begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (w_wb_hit[p]) r_busy[w_wb_row[p]][bus.wb_tag[p].slot] <= 1'b0;
         end
         if (w_pop) begin
            for (int s = 0; s < ROB_SLOTS; s++) begin
               r_valid[w_head][s] <= 1'b0;
               r_busy[w_head][s]  <= 1'b0;
            end
         end
         if (w_push) begin
            r_valid[w_tail][0] <= bus.dispatch_uop0.valid;
            r_busy[w_tail][0]  <= bus.dispatch_uop0.valid;
            r_valid[w_tail][1] <= bus.dispatch_uop1.valid;
            r_busy[w_tail][1]  <= bus.dispatch_uop1.valid;
         end
      end
   end

   // Payload storage carries no reset; the valid bits decide whether it is ever shown.
   always_ff @(posedge clk) begin
      if (!bus.flush) begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (w_wb_hit[p]) begin
               r_data[w_wb_row[p]][bus.wb_tag[p].slot] <=
                  rob_wb_merge(r_data[w_wb_row[p]][bus.wb_tag[p].slot], bus.wb_info[p]);
            end
         end
         if (w_push) begin
            r_data[w_tail][0] <= bus.dispatch_uop0;
            r_data[w_tail][1] <= bus.dispatch_uop1;
         end
      end
   end

   assign w_head_done    = !(r_valid[w_head][0] && r_busy[w_head][0])
                           && !(r_valid[w_head][1] && r_busy[w_head][1]);
   assign w_commit_valid = (w_count != '0) && w_head_done;

   always_comb begin
      bus.commit_uop0 = '0;
      bus.commit_uop1 = '0;
      if (w_commit_valid) begin
         if (r_valid[w_head][0]) begin
            bus.commit_uop0           = r_data[w_head][0];
            bus.commit_uop0.valid     = 1'b1;
            bus.commit_uop0.busy      = 1'b0;
            bus.commit_uop0.committed = 1'b0;
         end
         if (r_valid[w_head][1]) begin
            bus.commit_uop1           = r_data[w_head][1];
            bus.commit_uop1.valid     = 1'b1;
            bus.commit_uop1.busy      = 1'b0;
            bus.commit_uop1.committed = 1'b0;
         end
      end
   end

   assign bus.commit_valid   = w_commit_valid;
   assign bus.dispatch_ready = !w_full;
   assign bus.dispatch_row   = w_tail;
   assign bus.rob_empty      = w_empty;

endmodule

// File: tb/tb_rob_commit_source.sv
// Directed bench for rob_commit_source: allocation, writeback, in-order commit, full/wrap, flush and reset.
module tb_rob_commit_source;
   import rob_pkg::*;

   localparam int DEPTH    = 16;
   localparam int WB_PORTS = 4;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   rob_commit_source_if #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) bus ();

   rob_commit_source #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic rob_entry_t mk_uop(input logic [31:0] pc);
      rob_entry_t e;
      e            = '0;
      e.valid      = 1'b1;
      e.pc         = pc;
      e.dstLAddr   = pc[6:2];
      e.dstwe      = 1'b1;
      e.branchType = BR_NONE;
      return e;
   endfunction

   function automatic rob_wb_t mk_wb(input logic exc, input logic [4:0] code,
                                     input logic taken, input logic [31:0] addr);
      rob_wb_t w;
      w.branchTaken = taken;
      w.branchAddr  = addr;
      w.causeExc    = exc;
      w.exception   = exc;
      w.excCode     = ExceptionType'(code);
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      bus.flush          = 1'b0;
      bus.dispatch_valid = 1'b0;
      bus.dispatch_uop0  = '0;
      bus.dispatch_uop1  = '0;
      bus.wb_valid       = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         bus.wb_tag[p]  = '0;
         bus.wb_info[p] = '0;
      end
   endtask

   task automatic cycle();
      tick();
      clr_inputs();
   endtask

   task automatic set_disp(input rob_entry_t u0, input rob_entry_t u1);
      bus.dispatch_valid = 1'b1;
      bus.dispatch_uop0  = u0;
      bus.dispatch_uop1  = u1;
   endtask

   task automatic set_wb(input int p, input int row, input logic slot, input rob_wb_t info);
      bus.wb_valid[p]    = 1'b1;
      bus.wb_tag[p].row  = ROB_ROW_W'(row);
      bus.wb_tag[p].slot = slot;
      bus.wb_info[p]     = info;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b0;
      bus.commit_ready = 1'b0;
      clr_inputs();
      #2 rst = 1'b1;
      #1;
      check("rst_dready", bus.dispatch_ready, 1);
      check("rst_cvalid", bus.commit_valid, 0);
      check("rst_empty", bus.rob_empty, 1);
      check("rst_uop0", bus.commit_uop0, 0);
      tick();
      tick();
      rst = 1'b0;
      check("post_rst_empty", bus.rob_empty, 1);
      check("post_rst_row", bus.dispatch_row, 0);

      // Single row, slot 1 unused
      set_disp(mk_uop(32'h1000), '0);
      cycle();
      check("t1_busy_cvalid", bus.commit_valid, 0);
      check("t1_nonempty", bus.rob_empty, 0);
      set_wb(0, 0, 1'b0, '0);
      cycle();
      check("t1_cvalid", bus.commit_valid, 1);
      check("t1_pc", bus.commit_uop0.pc, 32'h1000);
      check("t1_u0valid", bus.commit_uop0.valid, 1);
      check("t1_uop1_zero", bus.commit_uop1, 0);
      bus.commit_ready = 1'b1;
      tick();
      bus.commit_ready = 1'b0;
      check("t1_empty", bus.rob_empty, 1);
      check("t1_cvalid_after", bus.commit_valid, 0);

      // Fill all rows starting at row 1 so the tail wraps 15 -> 0
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("t2_dready_%0d", i), bus.dispatch_ready, 1);
         check($sformatf("t2_row_%0d", i), bus.dispatch_row, (1 + i) % DEPTH);
         set_disp(mk_uop(32'h2000 + i * 8), mk_uop(32'h2004 + i * 8));
         cycle();
      end
      check("t2_full_dready", bus.dispatch_ready, 0);
      check("t2_full_cvalid", bus.commit_valid, 0);
      for (int c = 0; c < DEPTH / 2; c++) begin
         for (int k = 0; k < 4; k++) begin
            set_wb(k, (1 + c * 2 + k / 2) % DEPTH, k[0], '0);
         end
         cycle();
      end
      bus.commit_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("t2_cv_%0d", i), bus.commit_valid, 1);
         check($sformatf("t2_pc0_%0d", i), bus.commit_uop0.pc, 32'h2000 + i * 8);
         check($sformatf("t2_pc1_%0d", i), bus.commit_uop1.pc, 32'h2004 + i * 8);
         tick();
      end
      check("t2_empty", bus.rob_empty, 1);
      check("t2_row_after", bus.dispatch_row, 1);

      // Older row waits on its second slot while the younger row is complete
      set_disp(mk_uop(32'h7000), mk_uop(32'h7004));
      cycle();
      set_disp(mk_uop(32'h7100), '0);
      cycle();
      set_wb(0, 2, 1'b0, '0);
      set_wb(1, 1, 1'b0, '0);
      cycle();
      check("t3_wait0", bus.commit_valid, 0);
      tick();
      check("t3_wait1", bus.commit_valid, 0);
      set_wb(2, 1, 1'b1, '0);
      cycle();
      check("t3_cv_a", bus.commit_valid, 1);
      check("t3_pc_a0", bus.commit_uop0.pc, 32'h7000);
      check("t3_pc_a1", bus.commit_uop1.pc, 32'h7004);
      tick();
      check("t3_cv_b", bus.commit_valid, 1);
      check("t3_pc_b0", bus.commit_uop0.pc, 32'h7100);
      check("t3_b_uop1_zero", bus.commit_uop1, 0);
      tick();
      check("t3_empty", bus.rob_empty, 1);
      bus.commit_ready = 1'b0;

      // Exception/branch info, plus writebacks to an unallocated row and an unused slot
      set_disp(mk_uop(32'h3000), '0);
      cycle();
      set_wb(0, 4, 1'b0, mk_wb(1'b1, 5'd2, 1'b1, 32'h9999));
      set_wb(1, 3, 1'b1, '0);
      cycle();
      check("t4_ignored_cv", bus.commit_valid, 0);
      check("t4_row", bus.dispatch_row, 4);
      set_disp(mk_uop(32'h3100), '0);
      set_wb(0, 3, 1'b0, mk_wb(1'b1, 5'h0C, 1'b1, 32'h2000));
      cycle();
      check("t4_cv", bus.commit_valid, 1);
      check("t4_pc", bus.commit_uop0.pc, 32'h3000);
      check("t4_causeExc", bus.commit_uop0.causeExc, 1);
      check("t4_exception", bus.commit_uop0.exception, 1);
      check("t4_excCode", bus.commit_uop0.excCode, 5'h0C);
      check("t4_brTaken", bus.commit_uop0.branchTaken, 1);
      check("t4_brAddr", bus.commit_uop0.branchAddr, 32'h2000);
      bus.commit_ready = 1'b1;
      tick();
      check("t4_d_busy_cv", bus.commit_valid, 0);
      check("t4_d_nonempty", bus.rob_empty, 0);
      set_wb(3, 4, 1'b0, '0);
      cycle();
      check("t4_d_cv", bus.commit_valid, 1);
      check("t4_d_pc", bus.commit_uop0.pc, 32'h3100);
      check("t4_d_causeExc", bus.commit_uop0.causeExc, 0);
      check("t4_d_brAddr", bus.commit_uop0.branchAddr, 0);
      tick();
      check("t4_empty", bus.rob_empty, 1);
      bus.commit_ready = 1'b0;

      // Full ROB with commit and dispatch in the same cycle
      for (int i = 0; i < DEPTH; i++) begin
         set_disp(mk_uop(32'h4000 + i * 4), '0);
         cycle();
      end
      check("t5_full", bus.dispatch_ready, 0);
      check("t5_count16", dut.u_ptr.r_count, 16);
      for (int c = 0; c < 4; c++) begin
         for (int p = 0; p < 4; p++) set_wb(p, (5 + c * 4 + p) % DEPTH, 1'b0, '0);
         cycle();
      end
      check("t5_cv", bus.commit_valid, 1);
      check("t5_head_pc", bus.commit_uop0.pc, 32'h4000);
      bus.commit_ready = 1'b1;
      set_disp(mk_uop(32'h5000), '0);
      tick();
      check("t5_count15", dut.u_ptr.r_count, 15);
      check("t5_dready", bus.dispatch_ready, 1);
      check("t5_row", bus.dispatch_row, 5);
      check("t5_head_pc2", bus.commit_uop0.pc, 32'h4004);
      bus.commit_ready = 1'b0;
      tick();
      clr_inputs();
      check("t5_count16b", dut.u_ptr.r_count, 16);
      check("t5_full_again", bus.dispatch_ready, 0);

      // Asynchronous reset between clock edges
      #2 rst = 1'b1;
      #1;
      check("ar_empty", bus.rob_empty, 1);
      check("ar_dready", bus.dispatch_ready, 1);
      check("ar_cvalid", bus.commit_valid, 0);
      check("ar_row", bus.dispatch_row, 0);
      tick();
      rst = 1'b0;

      // Flush with five live rows and same-cycle dispatch, writeback and commit
      for (int i = 0; i < 5; i++) begin
         set_disp(mk_uop(32'h6000 + i * 4), '0);
         cycle();
      end
      set_wb(0, 0, 1'b0, '0);
      cycle();
      check("t6_pre_cv", bus.commit_valid, 1);
      bus.flush        = 1'b1;
      bus.commit_ready = 1'b1;
      set_disp(mk_uop(32'h6100), '0);
      set_wb(0, 1, 1'b0, '0);
      cycle();
      check("t6_count0", dut.u_ptr.r_count, 0);
      check("t6_empty", bus.rob_empty, 1);
      check("t6_cvalid", bus.commit_valid, 0);
      check("t6_row0", bus.dispatch_row, 0);
      check("t6_dready", bus.dispatch_ready, 1);
      set_disp(mk_uop(32'h6200), '0);
      cycle();
      check("t6_new_busy", bus.commit_valid, 0);
      check("t6_new_row", bus.dispatch_row, 1);
      set_wb(0, 0, 1'b0, '0);
      cycle();
      check("t6_new_cv", bus.commit_valid, 1);
      check("t6_new_pc", bus.commit_uop0.pc, 32'h6200);
      tick();
      check("t6_final_empty", bus.rob_empty, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
